// File: rtl/dma_engine.sv
// Command-driven DMA engine between the core's data memory and the CGRA.
// Moves multi-word blocks in either direction and sequences CGRA start/done.
module dma_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  input  logic [9:0]        funct_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              cmd_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cgra_re_o,
  output logic              cgra_we_o,
  output logic [ADDR_W-1:0] cgra_addr_o,
  output logic [DATA_W-1:0] cgra_wdata_o,
  input  logic [DATA_W-1:0] cgra_rdata_i,
  output logic              cgra_start_o,
  input  logic              cgra_done_i
);

  typedef enum logic [3:0] {
    IDLE, M_RD, M_CAP, C_WR, C_RD, C_CAP, M_WR, START, RUN, DONE
  } state_t;

  localparam logic [9:0]        FUNCT_STC = 10'd1;
  localparam logic [9:0]        FUNCT_LFC = 10'd2;
  localparam logic [9:0]        FUNCT_SCA = 10'd3;
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(DATA_W / 8);

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_nxt;
  logic [ADDR_W-1:0] idx_a;
  logic [ADDR_W-1:0] idx_nxt_a;
  logic              last;

  assign idx_nxt   = idx + 1'b1;
  assign idx_a     = ADDR_W'(idx);
  assign idx_nxt_a = ADDR_W'(idx_nxt);
  assign last      = (idx == len_q - 1'b1);

  // Outputs are registered: each transition loads the values the next state
  // presents, so every state sees its request/address/data from its first cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx          <= '0;
      cmd_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cgra_re_o    <= 1'b0;
      cgra_we_o    <= 1'b0;
      cgra_addr_o  <= '0;
      cgra_wdata_o <= '0;
      cgra_start_o <= 1'b0;
    end else begin
      cmd_ready_o  <= 1'b0;
      busy_o       <= 1'b1;
      done_o       <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cgra_re_o    <= 1'b0;
      cgra_we_o    <= 1'b0;
      cgra_addr_o  <= '0;
      cgra_wdata_o <= '0;
      cgra_start_o <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid_i && (funct_i == FUNCT_STC || funct_i == FUNCT_LFC ||
                              funct_i == FUNCT_SCA)) begin
            src_q <= src_addr_i;
            dst_q <= dst_addr_i;
            len_q <= len_i;
            idx   <= '0;
            if (funct_i == FUNCT_SCA) begin
              state        <= START;
              cgra_start_o <= 1'b1;
            end else if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else if (funct_i == FUNCT_STC) begin
              state      <= M_RD;
              mem_req_o  <= 1'b1;
              mem_addr_o <= src_addr_i;
            end else begin
              state       <= C_RD;
              cgra_re_o   <= 1'b1;
              cgra_addr_o <= src_addr_i;
            end
          end else begin
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end

        M_RD: begin
          if (mem_gnt_i) begin
            state <= M_CAP;
          end else begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= mem_addr_o;
          end
        end

        M_CAP: begin
          state        <= C_WR;
          cgra_we_o    <= 1'b1;
          cgra_addr_o  <= dst_q + idx_a;
          cgra_wdata_o <= mem_rdata_i;
        end

        C_WR: begin
          if (last) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            idx        <= idx_nxt;
            state      <= M_RD;
            mem_req_o  <= 1'b1;
            mem_addr_o <= src_q + idx_nxt_a * STEP;
          end
        end

        C_RD: state <= C_CAP;

        C_CAP: begin
          state       <= M_WR;
          mem_req_o   <= 1'b1;
          mem_we_o    <= 1'b1;
          mem_addr_o  <= dst_q + idx_a * STEP;
          mem_wdata_o <= cgra_rdata_i;
        end

        M_WR: begin
          if (!mem_gnt_i) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= mem_addr_o;
            mem_wdata_o <= mem_wdata_o;
          end else if (last) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            idx         <= idx_nxt;
            state       <= C_RD;
            cgra_re_o   <= 1'b1;
            cgra_addr_o <= src_q + idx_nxt_a;
          end
        end

        // A done level already present while start is pulsing belongs to the
        // previous run, so RUN is entered unconditionally.
        START: state <= RUN;

        RUN: begin
          if (cgra_done_i) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            state <= RUN;
          end
        end

        DONE: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Directed testbench for dma_engine: STC, LFC with grant stalls, SCA,
// zero length, no-op, asynchronous reset mid-transfer and 8-bit address wrap.
module tb_dma_engine;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [9:0]  funct;
  logic [31:0] src;
  logic [31:0] dst;
  logic [7:0]  len;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        cgra_re;
  logic        cgra_we;
  logic [31:0] cgra_addr;
  logic [31:0] cgra_wdata;
  logic [31:0] cgra_rdata;
  logic        cgra_start;
  logic        cgra_done;

  logic        w_cmd_valid;
  logic [9:0]  w_funct;
  logic [7:0]  w_src;
  logic [7:0]  w_dst;
  logic [7:0]  w_len;
  logic        w_cmd_ready;
  logic        w_busy;
  logic        w_done;
  logic        w_mem_req;
  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_cgra_re;
  logic        w_cgra_we;
  logic [7:0]  w_cgra_addr;
  logic [31:0] w_cgra_wdata;
  logic        w_cgra_start;

  int check_count = 0;
  int error_count = 0;

  dma_engine dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .funct_i(funct),
    .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
    .cmd_ready_o(cmd_ready), .busy_o(busy), .done_o(done),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rdata_i(mem_rdata),
    .cgra_re_o(cgra_re), .cgra_we_o(cgra_we), .cgra_addr_o(cgra_addr),
    .cgra_wdata_o(cgra_wdata), .cgra_rdata_i(cgra_rdata),
    .cgra_start_o(cgra_start), .cgra_done_i(cgra_done)
  );

  dma_engine #(.ADDR_W(8), .DATA_W(32), .LEN_W(8)) dut_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(w_cmd_valid), .funct_i(w_funct),
    .src_addr_i(w_src), .dst_addr_i(w_dst), .len_i(w_len),
    .cmd_ready_o(w_cmd_ready), .busy_o(w_busy), .done_o(w_done),
    .mem_req_o(w_mem_req), .mem_we_o(w_mem_we), .mem_addr_o(w_mem_addr),
    .mem_wdata_o(w_mem_wdata), .mem_gnt_i(1'b1), .mem_rdata_i(32'h0),
    .cgra_re_o(w_cgra_re), .cgra_we_o(w_cgra_we), .cgra_addr_o(w_cgra_addr),
    .cgra_wdata_o(w_cgra_wdata), .cgra_rdata_i(32'h0),
    .cgra_start_o(w_cgra_start), .cgra_done_i(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one command for a single cycle; returns just after the accept edge.
  task automatic apply_stimulus(input logic [9:0] f, input logic [31:0] s,
                                input logic [31:0] d, input logic [7:0] l);
    @(negedge clk);
    cmd_valid = 1'b1;
    funct     = f;
    src       = s;
    dst       = d;
    len       = l;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    funct     = '0;
    src       = '0;
    dst       = '0;
    len       = '0;
  endtask

  task automatic run_stc(input logic [31:0] s, input logic [31:0] d,
                         input logic [31:0] data_base, input logic [7:0] l,
                         output int done_cyc, output int rds, output int wrs,
                         output int busy_low);
    done_cyc = 0;
    rds      = 0;
    wrs      = 0;
    busy_low = 0;
    mem_gnt  = 1'b1;
    apply_stimulus(10'd1, s, d, l);
    for (int k = 1; k <= 60 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (mem_req && !mem_we) begin
        check_output("stc_rd_addr", mem_addr, s + 32'(4 * rds));
        mem_rdata = data_base + 32'(rds);
        rds++;
      end
      if (cgra_we) begin
        check_output("stc_wr_addr", cgra_addr, d + 32'(wrs));
        check_output("stc_wr_data", cgra_wdata, data_base + 32'(wrs));
        wrs++;
      end
      if (done) done_cyc = k;
    end
  endtask

  int done_cyc, rds, wrs, busy_low, wait_n, starts, start_cyc, done_n;
  int traffic, not_ready;
  logic [7:0] wrap_exp [3];

  initial begin
    rst_n       = 1'b1;
    cmd_valid   = 1'b0;
    funct       = '0;
    src         = '0;
    dst         = '0;
    len         = '0;
    mem_gnt     = 1'b0;
    mem_rdata   = '0;
    cgra_rdata  = '0;
    cgra_done   = 1'b0;
    w_cmd_valid = 1'b0;
    w_funct     = '0;
    w_src       = '0;
    w_dst       = '0;
    w_len       = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_mem_req", 32'(mem_req), 32'd0);
    rst_n = 1'b1;

    // STC, zero-wait grant, 4 words
    run_stc(32'h100, 32'h10, 32'hA0, 8'd4, done_cyc, rds, wrs, busy_low);
    check_output("stc_done_cycle", 32'(done_cyc), 32'd13);
    check_output("stc_reads", 32'(rds), 32'd4);
    check_output("stc_writes", 32'(wrs), 32'd4);
    check_output("stc_busy_low", 32'(busy_low), 32'd0);
    @(negedge clk);
    check_output("stc_ready_after", 32'(cmd_ready), 32'd1);
    check_output("stc_busy_after", 32'(busy), 32'd0);

    // LFC, two ungranted cycles per memory write
    mem_gnt  = 1'b0;
    rds      = 0;
    wrs      = 0;
    wait_n   = 0;
    done_cyc = 0;
    apply_stimulus(10'd2, 32'h20, 32'h200, 8'd3);
    for (int k = 1; k <= 60 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (cgra_re) begin
        check_output("lfc_rd_addr", cgra_addr, 32'h20 + 32'(rds));
        cgra_rdata = 32'h20 + 32'(rds);
        rds++;
      end
      if (mem_req && mem_we) begin
        check_output("lfc_wr_addr", mem_addr, 32'h200 + 32'(4 * wrs));
        check_output("lfc_wr_data", mem_wdata, 32'h20 + 32'(wrs));
        if (wait_n == 2) begin
          mem_gnt = 1'b1;
          wait_n  = 0;
          wrs++;
        end else begin
          mem_gnt = 1'b0;
          wait_n++;
        end
      end else begin
        mem_gnt = 1'b0;
      end
      if (done) done_cyc = k;
    end
    mem_gnt = 1'b0;
    check_output("lfc_done_cycle", 32'(done_cyc), 32'd16);
    check_output("lfc_writes", 32'(wrs), 32'd3);
    check_output("lfc_reads", 32'(rds), 32'd3);

    // SCA: done level during START must be ignored; real done 10 cycles after start
    starts    = 0;
    start_cyc = 0;
    done_cyc  = 0;
    done_n    = 0;
    apply_stimulus(10'd3, 32'h0, 32'h0, 8'd0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cgra_start) begin
        starts++;
        start_cyc = k;
      end
      if (done) begin
        done_n++;
        done_cyc = k;
      end
      cgra_done = (k == 1 || k == 11);
    end
    cgra_done = 1'b0;
    check_output("sca_start_count", 32'(starts), 32'd1);
    check_output("sca_start_cycle", 32'(start_cyc), 32'd1);
    check_output("sca_done_cycle", 32'(done_cyc), 32'd12);
    check_output("sca_done_count", 32'(done_n), 32'd1);

    // Zero-length STC
    traffic  = 0;
    done_n   = 0;
    done_cyc = 0;
    mem_gnt  = 1'b1;
    apply_stimulus(10'd1, 32'h100, 32'h10, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (mem_req || cgra_we || cgra_re) traffic++;
      if (done) begin
        done_n++;
        done_cyc = k;
      end
    end
    check_output("zero_done_cycle", 32'(done_cyc), 32'd1);
    check_output("zero_done_count", 32'(done_n), 32'd1);
    check_output("zero_traffic", 32'(traffic), 32'd0);

    // No-op funct
    not_ready = 0;
    done_n    = 0;
    traffic   = 0;
    apply_stimulus(10'h3FF, 32'h100, 32'h10, 8'd4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (!cmd_ready) not_ready++;
      if (done) done_n++;
      if (busy || mem_req || cgra_re || cgra_we || cgra_start) traffic++;
    end
    check_output("noop_not_ready", 32'(not_ready), 32'd0);
    check_output("noop_done", 32'(done_n), 32'd0);
    check_output("noop_activity", 32'(traffic), 32'd0);

    // Asynchronous reset during word 2 of an 8-word STC
    rds     = 0;
    mem_gnt = 1'b1;
    apply_stimulus(10'd1, 32'h400, 32'h80, 8'd8);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_req && !mem_we) begin
        mem_rdata = 32'hC0 + 32'(rds);
        rds++;
      end
    end
    check_output("rst_pre_cgra_we", 32'(cgra_we), 32'd1);
    check_output("rst_pre_cgra_addr", cgra_addr, 32'h81);
    #1 rst_n = 1'b0;
    #1;
    check_output("rst_cgra_we", 32'(cgra_we), 32'd0);
    check_output("rst_cgra_addr", cgra_addr, 32'd0);
    check_output("rst_cgra_wdata", cgra_wdata, 32'd0);
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_stc(32'h300, 32'h40, 32'hB0, 8'd2, done_cyc, rds, wrs, busy_low);
    check_output("post_rst_done_cycle", 32'(done_cyc), 32'd7);
    check_output("post_rst_reads", 32'(rds), 32'd2);
    check_output("post_rst_writes", 32'(wrs), 32'd2);

    // 8-bit address wrap on the second instance
    wrap_exp[0] = 8'hFC;
    wrap_exp[1] = 8'h00;
    wrap_exp[2] = 8'h04;
    rds      = 0;
    done_cyc = 0;
    @(negedge clk);
    w_cmd_valid = 1'b1;
    w_funct     = 10'd1;
    w_src       = 8'hFC;
    w_dst       = 8'h00;
    w_len       = 8'd3;
    @(posedge clk);
    #1;
    w_cmd_valid = 1'b0;
    w_funct     = '0;
    for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (w_mem_req) begin
        if (rds < 3) check_output("wrap_rd_addr", 32'(w_mem_addr), 32'(wrap_exp[rds]));
        rds++;
      end
      if (w_done) done_cyc = k;
    end
    check_output("wrap_reads", 32'(rds), 32'd3);
    check_output("wrap_done_cycle", 32'(done_cyc), 32'd10);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
# dma_engine

Parametrised, sequential DMA engine between the core's data memory and the CGRA. It replaces the purely combinational funct-to-control decode with a command-accepting state machine that moves multi-word blocks, holds memory requests until granted, and sequences CGRA start/done. It sits beside the execute stage: the core issues one command and is stalled through `busy_o` until `done_o` pulses.

## Interface
Parameters:
- `ADDR_W`, default 32: address width on both memory sides.
- `DATA_W`, default 32: word width. Main-memory address step is `DATA_W/8`.
- `LEN_W`, default 8: transfer-length width, in words.

Ports:
- `clk_i` in, 1: single clock; all state changes on the rising edge.
- `rst_n_i` in, 1: asynchronous, active-low reset.
- `cmd_valid_i` in, 1: command present.
- `funct_i` in, 10: command code. 1 = STC (memory to CGRA), 2 = LFC (CGRA to memory), 3 = SCA (start CGRA). All other values are no-op.
- `src_addr_i` in, ADDR_W: source base address.
- `dst_addr_i` in, ADDR_W: destination base address.
- `len_i` in, LEN_W: word count.
- `cmd_ready_o` out, 1: high only in IDLE.
- `busy_o` out, 1: high in every state except IDLE.
- `done_o` out, 1: one-cycle completion pulse.
- `mem_req_o` out, 1: main-memory request.
- `mem_we_o` out, 1: main-memory write enable.
- `mem_addr_o` out, ADDR_W: main-memory byte address.
- `mem_wdata_o` out, DATA_W: main-memory write data.
- `mem_gnt_i` in, 1: main-memory grant.
- `mem_rdata_i` in, DATA_W: main-memory read data, valid exactly 1 cycle after a read grant.
- `cgra_re_o` out, 1: CGRA read enable.
- `cgra_we_o` out, 1: CGRA write enable.
- `cgra_addr_o` out, ADDR_W: CGRA word address.
- `cgra_wdata_o` out, DATA_W: CGRA write data.
- `cgra_rdata_i` in, DATA_W: CGRA read data, valid 1 cycle after `cgra_re_o`.
- `cgra_start_o` out, 1: one-cycle CGRA start pulse.
- `cgra_done_i` in, 1: CGRA completion level/pulse.

## Operation
- **Accept**
  - Occurs when `cmd_valid_i & cmd_ready_o` and `funct_i` is 1, 2 or 3.
  - Latches funct, src, dst and len, and clears word index `i`.
  - A no-op funct is ignored: the engine stays in IDLE and no `done_o` is produced.
- **States:** IDLE, M_RD, M_CAP, C_WR, C_RD, C_CAP, M_WR, START, RUN, DONE.
- **STC** (M_RD → M_CAP → C_WR, per word)
  - M_RD: drives `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=src+i·(DATA_W/8). Held stable until `mem_gnt_i`.
  - M_CAP: registers `mem_rdata_i` into the word buffer.
  - C_WR: drives `cgra_we_o`=1, `cgra_addr_o`=dst+i, `cgra_wdata_o`=buffer.
  - After C_WR: go to DONE if i==len−1, else i++ and return to M_RD.
- **LFC** (C_RD → C_CAP → M_WR, per word)
  - C_RD: drives `cgra_re_o`=1, `cgra_addr_o`=src+i.
  - C_CAP: registers `cgra_rdata_i`.
  - M_WR: drives `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`=dst+i·(DATA_W/8), `mem_wdata_o`=buffer. Held until `mem_gnt_i`.
  - Loop and exit as for STC.
- **SCA**
  - START: `cgra_start_o`=1 for exactly one cycle.
  - RUN: wait for `cgra_done_i`; `cgra_done_i` sampled in START is ignored.
  - Then DONE.
- **Zero length:** len_i=0 with STC or LFC goes straight to DONE. No memory or CGRA traffic occurs.
- **DONE:** `done_o`=1 for one cycle, then IDLE.
- **Address arithmetic:** modulo 2^ADDR_W; wrap-around is silent.
- **Outputs outside their active states:** all request and enable outputs are 0, and address/data outputs are 0.
- **Reset**
  - Asserting `rst_n_i` at any time forces IDLE immediately.
  - Every output goes to 0 except `cmd_ready_o`, which goes to 1.
  - Internal registers clear.
  - Words already written stay written; the transfer is not resumed.

## Timing
- Accept-to-first-request: 1 cycle. The first state is entered on the accept edge.
- STC/LFC with zero-wait grant: 3 cycles per word. A transfer of N≥1 words takes 3N cycles, and `done_o` is high on cycle 3N+1 after the accept edge.
- Each grant wait cycle adds 1 cycle. Request, address, we and wdata must not change while ungranted.
- SCA: `cgra_start_o` is high in the cycle after accept. `done_o` is high in the cycle after `cgra_done_i` is sampled in RUN.
- `cmd_ready_o` returns high the cycle after `done_o`. Back-to-back commands are therefore spaced at least 1 IDLE cycle apart.

## Test plan
- **STC, no wait states:** STC, src=0x100, dst=0x10, len=4, `mem_gnt_i` tied 1, memory returns 0xA0..0xA3 → CGRA writes 0xA0..0xA3 to 0x10..0x13. Memory reads at 0x100, 0x104, 0x108, 0x10C. `done_o` on cycle 13; `busy_o` high for cycles 1–13.
- **LFC with grant stalls:** LFC, src=0x20, dst=0x200, len=3, `mem_gnt_i` delayed 2 cycles per write → writes to 0x200/0x204/0x208 carry CGRA words 0x20..0x22. Address and data stay stable while ungranted; `done_o` on cycle 16.
- **SCA:** SCA with `cgra_done_i` raised 10 cycles after start → exactly one `cgra_start_o` pulse; `done_o` exactly 1 cycle after `cgra_done_i`.
- **Zero length and no-op:** len=0 STC → `done_o` on cycle 1 with no `mem_req_o`/`cgra_we_o`. funct=0x3FF → no state change, `cmd_ready_o` stays 1, no `done_o`.
- **Reset mid-transfer:** `rst_n_i` pulled low during word 2 of a len=8 STC → all outputs 0 and `cmd_ready_o`=1 asynchronously. A new command accepted after release runs from i=0.
- **Address wrap:** ADDR_W=8, STC with src=0xFC, len=3 → memory reads at 0xFC, 0x00, 0x04.
